// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 keystream consumer.
package chacha_pkg;

    localparam int WORDS_PER_BLOCK = 16;

    typedef logic [31:0] word_t;

    // Row-major keystream block: word k lives at [k/4][k%4].
    typedef word_t [3:0][3:0] matrix_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        STREAM
    } kstream_state_t;

endpackage

// File: rtl/chacha_xor_outreg.sv
// Output holding register for the XOR stream with valid/ready semantics.
module chacha_xor_outreg
    import chacha_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  word_t      data_i,
    input  logic [3:0] keep_i,
    input  logic       last_i,
    input  logic       ready_i,
    output logic       valid_o,
    output word_t      data_o,
    output logic [3:0] keep_o,
    output logic       last_o
);

    logic       valid_q, valid_d;
    word_t      data_q, data_d;
    logic [3:0] keep_q, keep_d;
    logic       last_q, last_d;

    // Load on a transfer, drop valid once the consumer takes the word, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register; a reset drops any word still waiting for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: rtl/chacha_keystream_xor.sv
// Captures ChaCha20 keystream blocks from the core, XORs them onto a 32-bit
// message stream and requests the next block (with its counter) as needed.
module chacha_keystream_xor #(
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         init_counter,
    output logic [31:0]         block_counter,
    output logic                setRounds,
    input  chacha_pkg::matrix_t chachamatrixOUT,
    input  logic                blockready,
    input  logic [31:0]         in_data,
    input  logic [3:0]          in_keep,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [31:0]         out_data,
    output logic [3:0]          out_keep,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);
    import chacha_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLOCK - 1);

    kstream_state_t state_q, state_d;
    logic [31:0]    counter_q, counter_d;
    logic [3:0]     word_idx_q, word_idx_d;
    matrix_t        buf_q, buf_d;

    logic  xfer;
    word_t ks_word;
    word_t xor_data;

    assign in_ready      = (state_q == STREAM) && (!out_valid || out_ready);
    assign xfer          = in_valid && in_ready;
    assign setRounds     = (state_q == REQ);
    assign busy          = (state_q != IDLE);
    assign block_counter = counter_q;

    assign ks_word = buf_q[word_idx_q[3:2]][word_idx_q[1:0]];

    // Byte-wise XOR; bytes the sender marked invalid are zeroed.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign xor_data[8*gi +: 8] = in_keep[gi] ? (in_data[8*gi +: 8] ^ ks_word[8*gi +: 8]) : 8'h00;
        end
    endgenerate

    // Next-state logic: request, wait for the core, then stream one block.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        word_idx_d = word_idx_q;
        buf_d      = buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    counter_d = init_counter;
                    state_d   = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (blockready) begin
                    buf_d      = chachamatrixOUT;
                    word_idx_d = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    word_idx_d = word_idx_q + 4'd1;
                    if (in_last) begin
                        // Message done: the rest of the block is simply discarded.
                        state_d = IDLE;
                    end else if (word_idx_q == LAST_IDX) begin
                        counter_d = counter_q + 32'd1;
                        state_d   = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, index and keystream buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            counter_q  <= '0;
            word_idx_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            word_idx_q <= word_idx_d;
            buf_q      <= buf_d;
        end
    end

    chacha_xor_outreg u_outreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (xfer),
        .data_i  (xor_data),
        .keep_i  (in_keep),
        .last_i  (in_last),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .keep_o  (out_keep),
        .last_o  (out_last)
    );

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Randomized bench for chacha_keystream_xor with a message-level reference model.
module tb_chacha_keystream_xor;
    import chacha_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] init_counter = '0;
    logic [31:0] block_counter;
    logic        setRounds;
    matrix_t     chachamatrixOUT = '0;
    logic        blockready = 1'b0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_keep = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    always #5 clk = ~clk;

    chacha_keystream_xor #(.WORDS_PER_BLOCK(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .init_counter    (init_counter),
        .block_counter   (block_counter),
        .setRounds       (setRounds),
        .chachamatrixOUT (chachamatrixOUT),
        .blockready      (blockready),
        .in_data         (in_data),
        .in_keep         (in_keep),
        .in_last         (in_last),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_keep        (out_keep),
        .out_last        (out_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: every block the core handed out, and the message view.
    matrix_t     all_mats[$];
    beat_t       exp_q[$];
    int          msg_base = 0;
    int          msg_k = 0;
    int          nreq = 0;
    logic [31:0] msg_init = '0;
    logic [31:0] last_req_ctr = '0;
    logic [31:0] last_out_data = '0;
    logic [3:0]  last_out_keep = '0;
    logic        last_out_last = 1'b0;

    bit          expect_idle = 0, expect_req = 0, hold_prev = 0, sr_prev = 0;
    bit          sr_seen = 0, bp_now = 0, xfer_seen = 0, last_in_ready = 0;
    bit          spur_req = 0, preset_pending = 0, pend = 0;
    logic [31:0] preset_w0 = '0;
    int          dly = 0;
    logic [31:0] held_data = '0;
    logic [3:0]  held_keep = '0;
    logic        held_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp_v);
        end
    endtask

    // Sampled on the falling edge: checks outputs and advances the model.
    task automatic mon_step();
        beat_t       e;
        matrix_t     m;
        logic [31:0] ks, mask;
        int          b, w;
        if (rst) begin
            exp_q.delete();
            expect_idle = 0; expect_req = 0; hold_prev = 0; sr_prev = 0;
            sr_seen = 0; xfer_seen = 0; last_in_ready = 0;
            return;
        end
        if (expect_idle) begin chk("idle_after_last", 32'(busy), 32'd0); expect_idle = 0; end
        if (expect_req) begin chk("req_after_block", 32'(setRounds), 32'd1); expect_req = 0; end
        if (hold_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, held_data);
            chk("hold_keep", 32'(out_keep), 32'(held_keep));
            chk("hold_last", 32'(out_last), 32'(held_last));
        end
        if (setRounds) begin
            chk("setrounds_width", 32'(sr_prev), 32'd0);
            chk("block_counter_at_req", block_counter, msg_init + 32'(nreq));
            last_req_ctr = block_counter;
            nreq++;
        end
        if (bp_now) chk("in_ready_backpressure", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_queue_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_keep", 32'(out_keep), 32'(e.k));
                chk("out_last", 32'(out_last), 32'(e.l));
                last_out_data = out_data;
                last_out_keep = out_keep;
                last_out_last = out_last;
            end
        end
        xfer_seen = in_valid && in_ready;
        if (xfer_seen) begin
            b = msg_k / 16;
            w = msg_k % 16;
            if (msg_base + b >= all_mats.size()) begin
                chk("keystream_block_present", 32'(all_mats.size()), 32'(msg_base + b + 1));
            end else begin
                m    = all_mats[msg_base + b];
                ks   = m[w / 4][w % 4];
                mask = {{8{in_keep[3]}}, {8{in_keep[2]}}, {8{in_keep[1]}}, {8{in_keep[0]}}};
                e.d  = (in_data ^ ks) & mask;
                e.k  = in_keep;
                e.l  = in_last;
                exp_q.push_back(e);
            end
            if (in_last) expect_idle = 1;
            else if (w == 15) expect_req = 1;
            msg_k++;
        end
        if (start && !busy) begin
            msg_init = init_counter;
            msg_k    = 0;
            msg_base = all_mats.size();
            nreq     = 0;
        end
        hold_prev     = out_valid && !out_ready;
        held_data     = out_data;
        held_keep     = out_keep;
        held_last     = out_last;
        sr_seen       = setRounds;
        sr_prev       = setRounds;
        last_in_ready = in_ready;
    endtask

    // Plays the ChaCha core: answers each request after a random delay.
    task automatic core_step();
        matrix_t mt;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mt[r][c] = $urandom();
        blockready      = 1'b0;
        chachamatrixOUT = mt;
        if (rst) begin pend = 0; return; end
        if (sr_seen) begin pend = 1; dly = $urandom_range(0, 3); end
        if (pend) begin
            if (dly == 0) begin
                if (preset_pending) begin mt[0][0] = preset_w0; preset_pending = 0; end
                all_mats.push_back(mt);
                chachamatrixOUT = mt;
                blockready      = 1'b1;
                pend            = 0;
            end else begin
                dly--;
            end
        end else if (spur_req && last_in_ready) begin
            blockready = 1'b1;
            spur_req   = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
        core_step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_setRounds"}, 32'(setRounds), 32'd0);
        chk({tag, "_block_counter"}, block_counter, 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_keep"}, 32'(out_keep), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    endtask

    task automatic run_msg(input string tag, input int n, input logic [31:0] init,
                           input logic [3:0] lastkeep, input bit fix, input logic [31:0] fixdata,
                           input int bp_word, input bit extras, input bit use_preset,
                           input logic [31:0] w0, input int abort_at);
        int k, guard, hold, g;
        bit aborted;
        if (use_preset) begin preset_pending = 1; preset_w0 = w0; end
        start = 1'b1; init_counter = init;
        tick();
        start = 1'b0; init_counter = $urandom();
        k = 0; guard = 0; hold = 0; aborted = 0;
        while (k < n) begin
            if (abort_at >= 0 && k == abort_at) begin
                #2;
                rst = 1'b1;
                #1;
                check_reset_outputs("abort_reset");
                in_valid = 1'b0; bp_now = 0;
                tick();
                rst = 1'b0;
                aborted = 1;
                break;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = fix ? fixdata : $urandom();
            in_last  = (k == n - 1);
            in_keep  = in_last ? lastkeep : 4'hF;
            bp_now   = (hold > 0);
            if (bp_now) begin out_ready = 1'b0; hold--; end
            else out_ready = ($urandom_range(0, 4) != 0);
            start = extras && (k == 2 || k == n - 1);
            if (start) init_counter = 32'hDEAD_BEEF;
            if (extras && k == 5) spur_req = 1;
            tick();
            if (xfer_seen) begin
                if (k == bp_word) hold = 5;
                k++;
            end
            guard++;
            if (guard > 3000) begin chk("stream_progress", 32'(k), 32'(n)); break; end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; start = 1'b0; bp_now = 0;
        if (!aborted) begin
            g = 0;
            while ((busy || out_valid) && g < 100) begin tick(); g++; end
            chk("drain_idle", {30'd0, busy, out_valid}, 32'd0);
            chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
            chk("setrounds_pulses", 32'(nreq), 32'((n - 1) / 16 + 1));
        end
        $display("msg %s: %0d words, init 0x%08h, %0d requests, last out 0x%08h",
                 tag, n, init, nreq, last_out_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // RFC 8439 2.4.2 first keystream word over "Ladi".
        run_msg("rfc", 1, 32'd1, 4'hF, 1, 32'h6964614C, -1, 0, 1, 32'hF3514F22, -1);
        chk("rfc_word0", last_out_data, 32'h9A352E6E);
        chk("rfc_requests", 32'(nreq), 32'd1);

        // Partial last word.
        run_msg("partial", 1, 32'd7, 4'b0011, 1, 32'hFFFFFFFF, -1, 0, 1, 32'h12345678, -1);
        chk("partial_data", last_out_data, 32'h0000A987);
        chk("partial_keep", 32'(last_out_keep), 32'h3);
        chk("partial_last", 32'(last_out_last), 32'd1);

        // Rollover into a second block.
        run_msg("rollover", 20, 32'd1, 4'hF, 0, 32'd0, -1, 0, 0, 32'd0, -1);
        chk("rollover_requests", 32'(nreq), 32'd2);
        chk("rollover_ctr_req2", last_req_ctr, 32'd2);
        chk("rollover_ctr_hold", block_counter, 32'd2);

        // Backpressure after word 2.
        run_msg("backpressure", 10, 32'h100, 4'hF, 0, 32'd0, 2, 0, 0, 32'd0, -1);

        // Counter wrap with spurious blockready and start while busy.
        run_msg("wrap", 17, 32'hFFFFFFFF, 4'hF, 0, 32'd0, 4, 1, 0, 32'd0, -1);
        chk("wrap_ctr_req2", last_req_ctr, 32'h00000000);
        chk("wrap_ctr_hold", block_counter, 32'h00000000);

        // Reset in the middle of the second block.
        run_msg("abort", 30, 32'h55, 4'hF, 0, 32'd0, -1, 0, 0, 32'd0, 20);

        for (int i = 0; i < 8; i++) begin
            run_msg("random", $urandom_range(1, 40), $urandom(), 4'($urandom_range(1, 15)),
                    0, 32'd0, $urandom_range(0, 3) == 0 ? $urandom_range(0, 5) : -1,
                    $urandom_range(0, 1) == 1, 0, 32'd0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chacha_keystream_xor.md
# chacha_keystream_xor

Downstream consumer of the ChaCha20 block core (PerformQround). Captures each finished 4×4 keystream matrix when `blockready` is high and XORs it word-by-word with a 32-bit plaintext/ciphertext stream under valid/ready flow control. When a block is exhausted, it requests the next one by pulsing `setRounds` upstream. It also owns the 32-bit block counter that the matrix builder places in state word 12.

## Interface
Parameters:
- `WORDS_PER_BLOCK`, 16: keystream words per ChaCha20 block. Fixed by the algorithm; exposed for the bench only.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle pulse that begins a message. Accepted only in IDLE.
- `init_counter` in 32: block counter value sampled on an accepted `start`.
- `block_counter` out 32: counter value for the block currently requested or held.
- `setRounds` out 1: one-cycle request to the core to compute the next block.
- `chachamatrixOUT` in word_t [3:0][3:0]: finished block from the core.
- `blockready` in 1: core result is valid.
- `in_data` in 32: message word, little-endian bytes.
- `in_keep` in 4: byte valid mask. Must be 4'hF except on the last word.
- `in_last` in 1: marks the final message word.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `out_data` out 32, `out_keep` out 4, `out_last` out 1: XOR result and its sideband.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, STREAM.
- IDLE
  - On `start`, load `block_counter` from `init_counter` and go to REQ.
- REQ
  - Assert `setRounds` for exactly one cycle, then go to WAIT.
- WAIT
  - On `blockready`=1, copy all 16 words into the keystream buffer, clear `word_idx` (4-bit), and go to STREAM.
- STREAM
  - An input transfer occurs when `in_valid` && `in_ready`.
  - On a transfer: `out_data` = `in_data` ^ `buf[word_idx>>2][word_idx&3]`, with bytes where `in_keep`=0 forced to 0.
  - `out_keep` = `in_keep`, `out_last` = `in_last`.
  - `word_idx` increments on each transfer.
- Keystream word order is row-major: word k = matrix[k/4][k%4]. Byte b of word k is bits [8b+7:8b].
- End of block: when `word_idx`=15 is consumed without `in_last`, increment `block_counter` modulo 2^32 (wraps 0xFFFFFFFF→0) and go to REQ.
- End of message: a transfer with `in_last` (at any `word_idx`) discards the rest of the buffer and goes to IDLE.
  - `block_counter` does not increment.
  - No new request is issued.
- Ignored inputs:
  - `blockready` outside WAIT.
  - `start` outside IDLE.
  - `in_valid` outside STREAM (`in_ready`=0 there).
- Reset mid-operation clears all state immediately. A partially emitted output word is dropped.

## Timing
- Reset values:
  - State IDLE.
  - `setRounds`=0, `block_counter`=0, `in_ready`=0, `out_valid`=0, `busy`=0.
  - `out_data`=0, `out_keep`=0, `out_last`=0, buffer all zero.
- `in_ready` = (state==STREAM) && (!`out_valid` || `out_ready`). This is combinational and registered-output friendly.
- Latency: the output register is loaded on the transfer edge, so `out_valid` rises 1 cycle after the transfer.
- `out_valid` clears on `out_ready` unless a new transfer occurs in the same cycle.
- `out_*` are held stable while `out_valid` && !`out_ready`.
- Back-to-back throughput: 1 word/cycle within a block.
- Block boundary bubble: at least 2 cycles (REQ, then WAIT) plus the core's compute time.
- `start` and end-of-block on the same edge cannot occur. If `start` coincides with the final `in_last` transfer, it is ignored.
- `blockready` and reset in the same cycle: reset wins.

## Structure
- The shared package (`chacha_pkg`) holds:
  - `word_t` (logic [31:0]).
  - The `kstream_state_t` enum {IDLE, REQ, WAIT, STREAM}.
  - `WORDS_PER_BLOCK`.
- The shared package also holds a `matrix_t` typedef for word_t [3:0][3:0].
- One natural sub-module, `chacha_xor_outreg`: the output register and its valid/ready hold logic.
- The FSM, counter and buffer live in the top.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → all outputs read their reset values immediately, and `busy`=0.
- RFC 8439 §2.4.2 first word: `init_counter`=1, model drives matrix word0=0xF3514F22. Input 0x6964614C ("Ladi") with keep F → `out_data`=0x9A352E6E, and `setRounds` was pulsed exactly once.
- Block rollover: 20 full words with `in_last` on word 19 →
  - exactly 2 `setRounds` pulses;
  - `block_counter` goes 1→2;
  - words 16..19 are XORed with the second matrix's words 0..3;
  - returns to IDLE.
- Partial last word: last word with `in_keep`=4'b0011 and `in_data`=0xFFFFFFFF over keystream 0x12345678 → `out_data`=0x0000A987, `out_keep`=0011, `out_last`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after one transfer →
  - `in_ready`=0 throughout;
  - `out_data` is stable;
  - no word is lost or duplicated after release.
- Counter wrap and ignored inputs: `init_counter`=0xFFFFFFFF and 17 words → `block_counter`=0x00000000 on the second request.
  - A spurious `blockready` in STREAM has no effect.
  - `start` while busy has no effect.
